md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the E stage, with architectural HI/LO registers.
//  Executes mult/multu/div/divu over a fixed latency and mthi/mtlo in one cycle.
//  hi/lo feed the E-stage result selector (MUX_d32s2 input) for mfhi/mflo.
//  busy feeds the hazard unit, which stalls D while (start | busy) and an md-class instr is in D.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy is high for mult/multu (>=1)
//  DIV_CYCLES   10  cycles busy is high for div/divu (>=1)
// PORTS
//  clk     in   1   rising-edge clock, single clock domain
//  reset   in   1   synchronous, active-high reset
//  start   in   1   one-cycle request; md_op/src_a/src_b valid in the same cycle
//  md_op   in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op)
//  src_a   in   32  rs operand (forwarded); dividend / multiplicand / mthi-mtlo data
//  src_b   in   32  rt operand (forwarded); divisor / multiplier
//  busy    out  1   an operation is in flight
//  hi      out  32  HI register
//  lo      out  32  LO register
// BEHAVIOUR
//  Reset: on an edge with reset=1, hi=0, lo=0, busy=0, counter=0, pending result discarded.
//    reset has priority over start and over any in-flight completion.
//  Idle (cnt==0): at an edge with start=1:
//    mult:  pend = $signed(src_a)*$signed(src_b), 64-bit. cnt <= MULT_CYCLES.
//    multu: pend = unsigned 64-bit product. cnt <= MULT_CYCLES.
//    div:   pend_hi = signed remainder, pend_lo = signed quotient. cnt <= DIV_CYCLES.
//      Truncation is toward zero; the remainder takes the sign of the dividend (Verilog / and %).
//      0x80000000 / -1 gives lo=0x80000000 and hi=0.
//    divu:  pend_hi = src_a % src_b, pend_lo = src_a / src_b (unsigned). cnt <= DIV_CYCLES.
//    Divisor 0 (div/divu): busy runs the full DIV_CYCLES; hi/lo are left unchanged at completion.
//    mthi/mtlo: hi (resp. lo) <= src_a at that same edge; busy stays 0; the other register is unchanged.
//    Reserved md_op: no state change.
//  Busy: busy = (cnt != 0), registered. For start sampled at edge k, busy is 1 during cycles k+1 .. k+N.
//    At edge k+N (when cnt==1): {hi,lo} <= pend and cnt <= 0. busy is low and results are visible in cycle k+N+1.
//    Otherwise cnt decrements by 1 per edge.
//    hi/lo hold their old values throughout the busy window.
//  start while busy (any op, including mthi/mtlo): ignored.
//    There is no state change and no queueing. The hazard unit guarantees this does not occur.
//  Operands are captured at the start edge; later changes to src_a/src_b have no effect.
//  No flush input. An in-flight op always completes unless reset.
// TESTING
//  1. mult, src_a=0xFFFFFFFD (-3), src_b=5 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. multu, 0xFFFFFFFF*0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
//  3. div, -7/2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu, 7/2 -> lo=3, hi=1.
//  4. div by 0 with hi=0x11, lo=0x22 -> busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
//  5. mult 2*3, then at busy cycle 2 pulse start with mtlo 0x55 -> ignored; final lo=6, hi=0.
//     mthi 0xAB when idle -> hi=0xAB the next cycle, busy stays 0.
//  6. divu 100/7, reset asserted at busy cycle 4 -> next cycle busy=0, hi=lo=0.
//     Completion never lands; a following mult 4*4 yields lo=16.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at the start edge and retired after a fixed busy window.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    logic [CW-1:0]      cnt;
    md_res_t            pend;
    md_res_t            res;
    logic               sdiv;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    // Signed division runs on magnitudes so INT_MIN / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        sdiv   = (md_op == OP_DIV);
        mag_a  = (sdiv && src_a[31]) ? -src_a : src_a;
        mag_b  = (sdiv && src_b[31]) ? -src_b : src_b;
        q_mag  = (mag_b != 32'd0) ? mag_a / mag_b : 32'd0;
        r_mag  = (mag_b != 32'd0) ? mag_a % mag_b : 32'd0;
        prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u = {32'd0, src_a} * {32'd0, src_b};
        res    = '0;
        case (md_op)
            OP_MULT: begin
                res.wr = 1'b1;
                res.hi = prod_s[63:32];
                res.lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res.wr = 1'b1;
                res.hi = prod_u[63:32];
                res.lo = prod_u[31:0];
            end
            OP_DIV: begin
                res.wr = (src_b != 32'd0);
                res.lo = (src_a[31] ^ src_b[31]) ? -q_mag : q_mag;
                res.hi = src_a[31] ? -r_mag : r_mag;
            end
            OP_DIVU: begin
                res.wr = (src_b != 32'd0);
                res.lo = q_mag;
                res.hi = r_mag;
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            pend <= '0;
        end else if (cnt == '0) begin
            if (start) begin
                case (md_op)
                    OP_MULT, OP_MULTU: begin
                        pend <= res;
                        cnt  <= CW'(MULT_CYCLES);
                    end
                    OP_DIV, OP_DIVU: begin
                        pend <= res;
                        cnt  <= CW'(DIV_CYCLES);
                    end
                    OP_MTHI: hi <= src_a;
                    OP_MTLO: lo <= src_a;
                    default: ;
                endcase
            end
        end else begin
            // Divide-by-zero keeps wr low, so HI/LO survive the completion edge.
            if (cnt == CW'(1) && pend.wr) begin
                hi <= pend.hi;
                lo <= pend.lo;
            end
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed spec cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: updates m_hi/m_lo as the architecture defines, returns busy length.
    function automatic int model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint ps;
        longint unsigned pu;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                ps = longint'(sa) * longint'(sb);
                m_hi = ps[63:32];
                m_lo = ps[31:0];
                return MC;
            end
            3'd1: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = pu[63:32];
                m_lo = pu[31:0];
                return MC;
            end
            3'd2: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
                return DC;
            end
            3'd3: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                return DC;
            end
            3'd4: begin m_hi = a; return 0; end
            3'd5: begin m_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse across one edge, then scramble operands.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        md_op = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        md_op = 3'd4;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'd0;
        step();
        step();
        reset = 1'b0;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%0b hi=%h lo=%h, expected 0/0/0", busy, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_arith();
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2};
        logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] eh  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [31:0] el  [5] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000};
        int          lat [5] = '{MC, MC, DC, DC, DC};
        for (int t = 0; t < 5; t++) begin
            issue(ops[t], as[t], bs[t]);
            for (int i = 0; i < lat[t]; i++) begin
                vectors++;
                if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
                    miscompares++;
                    $display("FAIL arith_window[%0d] cyc%0d: busy=%0b hi=%h lo=%h, expected 1 %h %h",
                             t, i + 1, busy, hi, lo, m_hi, m_lo);
                end
                step();
            end
            vectors++;
            if (busy !== 1'b0 || hi !== eh[t] || lo !== el[t]) begin
                miscompares++;
                $display("FAIL arith_result[%0d]: busy=%0b hi=%h lo=%h, expected 0 %h %h",
                         t, busy, hi, lo, eh[t], el[t]);
            end
            m_hi = eh[t];
            m_lo = el[t];
        end
    endtask

    task automatic test_divzero();
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        vectors++;
        if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL divzero_setup: hi=%h lo=%h busy=%0b, expected 11 22 0", hi, lo, busy);
        end
        for (int t = 0; t < 2; t++) begin
            issue(t == 0 ? 3'd2 : 3'd3, 32'h1234_5678, 32'd0);
            for (int i = 0; i < DC; i++) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL divzero_busy[%0d] cyc%0d: busy=%0b, expected 1", t, i + 1, busy);
                end
                step();
            end
            vectors++;
            if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
                miscompares++;
                $display("FAIL divzero_result[%0d]: busy=%0b hi=%h lo=%h, expected 0 11 22", t, busy, hi, lo);
            end
        end
        m_hi = 32'h11;
        m_lo = 32'h22;
    endtask

    task automatic test_ignore_while_busy();
        issue(3'd0, 32'd2, 32'd3);
        for (int i = 0; i < MC; i++) begin
            vectors++;
            if (busy !== 1'b1 || lo !== m_lo || hi !== m_hi) begin
                miscompares++;
                $display("FAIL ignore_window cyc%0d: busy=%0b hi=%h lo=%h, expected 1 %h %h",
                         i + 1, busy, hi, lo, m_hi, m_lo);
            end
            if (i == 1) begin
                start = 1'b1;
                md_op = 3'd5;
                src_a = 32'h55;
            end
            step();
            start = 1'b0;
        end
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
            miscompares++;
            $display("FAIL ignore_result: busy=%0b hi=%h lo=%h, expected 0 0 6", busy, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd6;
    endtask

    task automatic test_mthi();
        issue(3'd4, 32'hAB, 32'd0);
        vectors++;
        if (hi !== 32'hAB || lo !== 32'd6 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_idle: hi=%h lo=%h busy=%0b, expected ab 6 0", hi, lo, busy);
        end
        m_hi = 32'hAB;
    endtask

    task automatic test_reset_midop();
        issue(3'd3, 32'd100, 32'd7);
        for (int i = 1; i < 4; i++) step();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy4: busy=%0b, expected 1", busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL rstmid_cleared: busy=%0b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
        for (int i = 0; i < DC; i++) step();
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL rstmid_no_landing: busy=%0b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
        issue(3'd0, 32'd4, 32'd4);
        for (int i = 0; i < MC; i++) step();
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd16) begin
            miscompares++;
            $display("FAIL rstmid_followup: busy=%0b hi=%h lo=%h, expected 0 0 10", busy, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd16;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] ph, pl;
        int          lat;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            ph  = m_hi;
            pl  = m_lo;
            lat = model_op(op, a, b);
            issue(op, a, b);
            for (int i = 0; i < lat; i++) begin
                vectors++;
                if (busy !== 1'b1 || hi !== ph || lo !== pl) begin
                    miscompares++;
                    $display("FAIL rand_window[%0d] op%0d cyc%0d: busy=%0b hi=%h lo=%h, expected 1 %h %h",
                             n, op, i + 1, busy, hi, lo, ph, pl);
                end
                start = ($urandom_range(0, 3) == 0);
                step();
                start = 1'b0;
            end
            vectors++;
            if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                miscompares++;
                $display("FAIL rand_result[%0d] op%0d a=%h b=%h: busy=%0b hi=%h lo=%h, expected 0 %h %h",
                         n, op, a, b, busy, hi, lo, m_hi, m_lo);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        step();
        test_reset();
        test_arith();
        test_divzero();
        test_ignore_while_busy();
        test_mthi();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
